// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-way round-robin arbiter with registered one-hot grant and optional max-hold preemption
//   clk      sole clock, rising edge
//   rst_n    asynchronous active-low reset
//   req      [N]    request per master, held until granted, dropped to release
//   gnt      [N]    registered one-hot-or-zero grant
//   gnt_id   [ID_W] binary index of current owner, valid when gnt_vld
//   gnt_vld  1      registered |gnt
//   preempt  1      one-cycle pulse when MAX_HOLD forced the grant away
module rr_arbiter_n #(
  parameter int N = 4,
  parameter int MAX_HOLD = 0,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_vld,
  output logic            preempt
);
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  typedef enum logic {IDLE, OWN} state_t;
  state_t state;
  logic [ID_W-1:0] last, win;
  logic [CW-1:0] cnt;
  logic found, hold, pre, others;
  // last always equals the current owner, so one search from last+1 serves
  // fresh grants, releases and preemption (the owner sorts last in the rotation)
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(last) + 1 + i) % N]) begin
        found = 1'b1;
        win = ID_W'((int'(last) + 1 + i) % N);
      end
    end
  end
  assign others = |(req & ~gnt);
  // >= rather than == so a saturated counter still preempts once a rival appears
  assign pre = (MAX_HOLD > 0) && (int'(cnt) >= MAX_HOLD - 1) && req[gnt_id] && others;
  assign hold = req[gnt_id] && !pre;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      gnt_vld <= 1'b0;
      preempt <= 1'b0;
      cnt <= '0;
      last <= ID_W'(N - 1);
    end else begin
      preempt <= 1'b0;
      if (state == OWN && hold) begin
        cnt <= (int'(cnt) == MAX_HOLD) ? cnt : cnt + 1'b1;
      end else if (found) begin
        state <= OWN;
        gnt <= N'(1) << win;
        gnt_id <= win;
        gnt_vld <= 1'b1;
        last <= win;
        cnt <= '0;
        preempt <= (state == OWN) && pre;
      end else begin
        state <= IDLE;
        gnt <= '0;
        gnt_vld <= 1'b0;
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb_rr_arbiter_n: directed scoreboard bench for rr_arbiter_n (one plain instance, one with MAX_HOLD=4)
module tb_rr_arbiter_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_a = '0, req_b = '0;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] id_a, id_b;
  logic vld_a, vld_b, pre_a, pre_b;
  int compared = 0;
  int mismatched = 0;

  rr_arbiter_n #(.N(4), .MAX_HOLD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a), .gnt_id(id_a), .gnt_vld(vld_a), .preempt(pre_a)
  );
  rr_arbiter_n #(.N(4), .MAX_HOLD(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b), .gnt_id(id_b), .gnt_vld(vld_b), .preempt(pre_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    bit b;
    logic [3:0] g;
    logic [1:0] id;
    bit cid;
    logic p;
  } exp_t;
  exp_t sb[$];

  task automatic push(input string tag, input bit b, input logic [3:0] g, input logic p, input bit cid);
    exp_t e;
    e.tag = tag;
    e.b = b;
    e.g = g;
    e.id = '0;
    for (int i = 0; i < 4; i++) if (g[i]) e.id = 2'(i);
    e.cid = cid || (|g);
    e.p = p;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [3:0] g;
    logic [1:0] id;
    logic v, p;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL sb_empty: no expectation queued");
      return;
    end
    e = sb.pop_front();
    g = e.b ? gnt_b : gnt_a;
    id = e.b ? id_b : id_a;
    v = e.b ? vld_b : vld_a;
    p = e.b ? pre_b : pre_a;
    compared++;
    assert (g === e.g) else begin
      mismatched++;
      $error("FAIL %s gnt got %b exp %b", e.tag, g, e.g);
    end
    compared++;
    assert (v === (|e.g)) else begin
      mismatched++;
      $error("FAIL %s gnt_vld got %b exp %b", e.tag, v, |e.g);
    end
    compared++;
    assert (p === e.p) else begin
      mismatched++;
      $error("FAIL %s preempt got %b exp %b", e.tag, p, e.p);
    end
    if (e.cid) begin
      compared++;
      assert (id === e.id) else begin
        mismatched++;
        $error("FAIL %s gnt_id got %0d exp %0d", e.tag, id, e.id);
      end
    end
  endtask

  task automatic cyc(input string tag, input bit b, input logic [3:0] r, input logic [3:0] g, input logic p = 1'b0);
    if (b) req_b = r;
    else req_a = r;
    push(tag, b, g, p, 1'b0);
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic async_reset(input string tag);
    #3 rst_n = 1'b0;
    #1;
    push(tag, 1'b0, 4'b0000, 1'b0, 1'b1);
    check();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req_a = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    push("reset_a", 1'b0, 4'b0000, 1'b0, 1'b1);
    push("reset_b", 1'b1, 4'b0000, 1'b0, 1'b1);
    check();
    check();
    #2 rst_n = 1'b1;
    cyc("first_0", 0, 4'b1111, 4'b0001);
    cyc("hold_0a", 0, 4'b1111, 4'b0001);
    cyc("hold_0b", 0, 4'b1111, 4'b0001);
    cyc("rot_1", 0, 4'b1110, 4'b0010);
    cyc("hold_1a", 0, 4'b1111, 4'b0010);
    cyc("hold_1b", 0, 4'b1111, 4'b0010);
    cyc("rot_2", 0, 4'b1101, 4'b0100);
    cyc("hold_2a", 0, 4'b1111, 4'b0100);
    cyc("hold_2b", 0, 4'b1111, 4'b0100);
    cyc("rot_3", 0, 4'b1011, 4'b1000);
    cyc("hold_3a", 0, 4'b1111, 4'b1000);
    cyc("hold_3b", 0, 4'b1111, 4'b1000);
    cyc("rot_0", 0, 4'b0111, 4'b0001);
    cyc("to_1", 0, 4'b0010, 4'b0010);
    cyc("release", 0, 4'b0000, 4'b0000);
    cyc("single_2", 0, 4'b0100, 4'b0100);
    cyc("idle", 0, 4'b0000, 4'b0000);
    cyc("pre_g1", 1, 4'b0011, 4'b0001);
    cyc("pre_g2", 1, 4'b0011, 4'b0001);
    cyc("pre_g3", 1, 4'b0011, 4'b0001);
    cyc("pre_g4", 1, 4'b0011, 4'b0001);
    cyc("preempt", 1, 4'b0011, 4'b0010, 1'b1);
    cyc("pre_after", 1, 4'b0011, 4'b0010);
    cyc("pre_back0", 1, 4'b0001, 4'b0001);
    for (int i = 0; i < 8; i++) cyc("no_preempt", 1, 4'b0001, 4'b0001);
    cyc("b_idle", 1, 4'b0000, 4'b0000);
    cyc("own_3", 0, 4'b1000, 4'b1000);
    async_reset("async_rst1");
    cyc("after_rst", 0, 4'b1000, 4'b1000);
    cyc("own_0", 0, 4'b0001, 4'b0001);
    async_reset("async_rst2");
    cyc("ptr_reset", 0, 4'b0011, 4'b0001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
